// File: rtl/rate_meter.sv
// rate_meter: measures the period of a slow periodic input in clk cycles and
// turns it back into a speed word, floor(MAX_SPEED / period), using a
// bit-serial restoring divider. The result is flagged with a one-cycle valid
// pulse. If no edge arrives within TIMEOUT cycles, the input is reported as
// stalled.
module rate_meter #(
    parameter int MAX_SPEED = 50000000,
    parameter int TIMEOUT   = 67108863
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic [25:0] period,
    output logic [25:0] speed,
    output logic        valid,
    output logic        stalled
);

    localparam int W = 26;
    localparam logic [W-1:0] MAX_W     = W'(MAX_SPEED);
    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
    localparam logic [4:0]   LAST_ITER = 5'(W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         s1_q, s2_q, s3_q;
    logic         rise;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;      // captured period, used as the divisor
    logic [W-1:0] rem_q, rem_d;      // partial remainder; always < divisor, so 26 bits hold it
    logic [W-1:0] dvd_q, dvd_d;      // dividend bits not yet consumed, MSB first
    logic [W-1:0] quo_q, quo_d;
    logic [4:0]   iter_q, iter_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] speed_q, speed_d;
    logic         valid_q, valid_d;
    logic         stalled_q, stalled_d;

    // One restoring-division step: shift in the next dividend bit, then
    // subtract the divisor when the result is not negative.
    logic [W:0]   rem_shift;
    logic [W:0]   rem_diff;
    logic         take;
    logic [W-1:0] rem_next;
    logic [W-1:0] quo_next;

    assign rem_shift = {rem_q, dvd_q[W-1]};
    assign rem_diff  = rem_shift - {1'b0, div_q};
    assign take      = ~rem_diff[W];
    assign rem_next  = take ? rem_diff[W-1:0] : rem_shift[W-1:0];
    assign quo_next  = {quo_q[W-2:0], take};

    assign rise = s2_q & ~s3_q;

    // Two-flop synchronizer plus a history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State, counter, divider and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            iter_q    <= '0;
            period_q  <= '0;
            speed_q   <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            iter_q    <= iter_d;
            period_q  <= period_d;
            speed_q   <= speed_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    // Next-state logic: edge counting, capture, timeout and serial divide
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        iter_d    = iter_q;
        period_d  = period_q;
        speed_d   = speed_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;

        // The counter restarts on every edge. A rise during DIVIDE still
        // restarts it, so that edge becomes the start of the next measurement.
        if (rise) begin
            cnt_d = W'(1);
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q >= TIMEOUT_W) begin
            cnt_d = TIMEOUT_W;
        end else begin
            cnt_d = cnt_q + W'(1);
        end

        case (state_q)
            IDLE: begin
                // The first edge only starts timing; there is no earlier edge.
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    div_d   = cnt_q;
                    rem_d   = '0;
                    dvd_d   = MAX_W;
                    quo_d   = '0;
                    iter_d  = '0;
                    state_d = DIVIDE;
                end else if (cnt_q == TIMEOUT_W) begin
                    stalled_d = 1'b1;
                    period_d  = '0;
                    speed_d   = '0;
                    state_d   = IDLE;
                end
            end
            DIVIDE: begin
                rem_d  = rem_next;
                dvd_d  = {dvd_q[W-2:0], 1'b0};
                quo_d  = quo_next;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    speed_d   = quo_next;
                    period_d  = div_q;
                    valid_d   = 1'b1;
                    stalled_d = 1'b0;
                    state_d   = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign period  = period_q;
    assign speed   = speed_q;
    assign valid   = valid_q;
    assign stalled = stalled_q;

endmodule

// File: tb/tb_rate_meter.sv
// tb_rate_meter: directed bench for rate_meter. Instance A uses the default
// parameters and covers basic, period-change and round-trip cases. Instance B
// uses TIMEOUT=500 and covers short-period, timeout and reset-mid-divide
// cases. Expected {period, speed} pairs are queued when an edge is driven and
// popped when valid pulses.
module tb_rate_meter;

    localparam int MAXS = 50000000;
    localparam int HI   = 4;

    typedef struct {
        int p;
        int s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        sig_a, sig_b;
    logic [25:0] period_a, speed_a, period_b, speed_b;
    logic        valid_a, stalled_a, valid_b, stalled_b;

    always #5 clk = ~clk;

    rate_meter dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .sig_in  (sig_a),
        .period  (period_a),
        .speed   (speed_a),
        .valid   (valid_a),
        .stalled (stalled_a)
    );

    rate_meter #(.TIMEOUT(500)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .sig_in  (sig_b),
        .period  (period_b),
        .speed   (speed_b),
        .valid   (valid_b),
        .stalled (stalled_b)
    );

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   have_prev[2];
    int   last_edge[2];
    int   last_cap[2];
    logic vprev_a = 1'b0;
    logic vprev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Raise the input now, keep it high for HI cycles, then keep it low until
    // wait_after cycles have passed since the raise. A raise is measured only
    // when it follows an earlier edge and falls outside the 26-cycle divide
    // that started at the last measured edge.
    task automatic raise(input int sel, input int wait_after);
        exp_t e;
        if (sel == 0) sig_a = 1'b1;
        else          sig_b = 1'b1;
        if (have_prev[sel] != 0 && (cyc - last_cap[sel]) >= 27) begin
            e.p = cyc - last_edge[sel];
            e.s = MAXS / e.p;
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
            last_cap[sel] = cyc;
        end
        last_edge[sel] = cyc;
        have_prev[sel] = 1;
        repeat (HI) @(negedge clk);
        if (sel == 0) sig_a = 1'b0;
        else          sig_b = 1'b0;
        repeat (wait_after - HI) @(negedge clk);
    endtask

    task automatic drain(input int sel);
        int sz;
        sz = (sel == 0) ? q_a.size() : q_b.size();
        for (int i = 0; i < 200 && sz != 0; i++) begin
            @(negedge clk);
            sz = (sel == 0) ? q_a.size() : q_b.size();
        end
        check(sel == 0 ? "a_drain" : "b_drain", sz, 0);
    endtask

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        exp_t e;
        if (valid_a) begin
            check("a_valid_one_cycle", vprev_a, 0);
            check("a_valid_vs_stalled", stalled_a, 0);
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", valid_a, 0);
            end else begin
                e = q_a.pop_front();
                check("a_period", period_a, e.p);
                check("a_speed", speed_a, e.s);
            end
        end
        vprev_a <= valid_a;
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        exp_t e;
        if (valid_b) begin
            check("b_valid_one_cycle", vprev_b, 0);
            check("b_valid_vs_stalled", stalled_b, 0);
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", valid_b, 0);
            end else begin
                e = q_b.pop_front();
                check("b_period", period_b, e.p);
                check("b_speed", speed_b, e.s);
            end
        end
        vprev_b <= valid_b;
    end

    initial begin
        int t_last;
        rst_a = 1'b1;
        rst_b = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            have_prev[k] = 0;
            last_edge[k] = 0;
            last_cap[k]  = -1000;
        end
        repeat (3) @(negedge clk);
        check("rst_a_period", period_a, 0);
        check("rst_a_speed", speed_a, 0);
        check("rst_a_valid", valid_a, 0);
        check("rst_a_stalled", stalled_a, 0);
        check("rst_b_period", period_b, 0);
        check("rst_b_speed", speed_b, 0);
        check("rst_b_valid", valid_b, 0);
        check("rst_b_stalled", stalled_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Basic measurement: period 100
        for (int i = 0; i < 6; i++) raise(0, 100);
        // Period change: one 400-cycle gap, then period 1000
        raise(0, 400);
        for (int i = 0; i < 3; i++) raise(0, 1000);
        // Round trip: divider output for speed 1250 has period 40000
        raise(0, 40000);
        raise(0, 60);
        drain(0);
        check("a_hold_period", period_a, 40000);
        check("a_hold_speed", speed_a, 1250);

        // Short period: every other edge lands inside the divide
        for (int i = 0; i < 9; i++) raise(1, 20);
        t_last = last_edge[1];
        drain(1);
        while (cyc - t_last < 400) @(negedge clk);
        check("b_no_early_stall", stalled_b, 0);
        for (int i = 0; i < 300 && !stalled_b; i++) @(negedge clk);
        check("b_stalled", stalled_b, 1);
        check("b_stall_period", period_b, 0);
        check("b_stall_speed", speed_b, 0);
        have_prev[1] = 0;

        // Restart after stall: needs two edges before stalled clears
        raise(1, 200);
        check("b_still_stalled", stalled_b, 1);
        raise(1, 200);
        check("b_stall_cleared", stalled_b, 0);
        raise(1, 200);

        // Reset 10 cycles after a capture aborts the divide
        raise(1, 12);
        rst_b = 1'b1;
        q_b.delete();
        have_prev[1] = 0;
        last_cap[1]  = -1000;
        @(negedge clk);
        rst_b = 1'b0;
        check("b_rst_period", period_b, 0);
        check("b_rst_speed", speed_b, 0);
        check("b_rst_valid", valid_b, 0);
        check("b_rst_stalled", stalled_b, 0);
        raise(1, 200);
        raise(1, 200);
        drain(1);
        check("b_final_period", period_b, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
